commit_trace_tx: RTL and testbench

//  Hardware commit-trace transmitter for the pipelined MIPS core. Samples the
//  WB-stage register-write and MEM-stage load/store events each cycle, queues

---
 rtl/commit_trace_tx.sv | 183 ++++++++++++++++++
 tb/tb_commit_trace_tx.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_tx.sv
// Commit-trace transmitter: samples WB register writes and MEM loads/stores,
// queues them as events and streams each as a 2-beat packet (header, value)
// over a valid/ready port.
// Build option: define TRACE_TS_ONLY_EN to record register writes only for
// $t0-$s7 (regs 8..23); otherwise every nonzero destination is recorded.
module commit_trace_tx #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned DROP_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_trace_en,
    input  logic              i_wb_regwrite,
    input  logic [4:0]        i_wb_reg,
    input  logic [31:0]       i_wb_data,
    input  logic [31:0]       i_wb_pc,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [31:0]       i_mem_addr,
    input  logic [31:0]       i_mem_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [31:0]       o_out_data,
    output logic              o_out_last,
    output logic              o_overflow,
    output logic              o_proto_err,
    output logic [DROP_W-1:0] o_drop_cnt
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StHdr, StVal} state_e;

    // Each entry holds the complete packet: {header, value}.
    logic [63:0]       r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr, r_rd_ptr;
    state_e            r_state;
    logic              r_out_valid, r_out_last;
    logic [31:0]       r_out_data;
    logic              r_overflow, r_proto_err;
    logic [DROP_W-1:0] r_drop_cnt;

    logic [AW:0]       w_count, w_free;
    logic              w_regw_ok, w_regw_ev, w_mem_ev, w_proto;
    logic              w_push_regw, w_push_mem, w_pop;
    logic [1:0]        w_n_drop, w_mem_type;
    logic [63:0]       w_regw_entry, w_mem_entry, w_head, w_next;
    logic [AW-1:0]     w_mem_idx;
    logic [DROP_W:0]   w_drop_sum;
    logic [DROP_W-1:0] w_drop_cnt_d;
    logic              w_unused_bits;

    assign w_count = r_wr_ptr - r_rd_ptr;
    // Free space is taken before this cycle's pop: no bypass of a full queue.
    assign w_free  = (AW+1)'(DEPTH) - w_count;

`ifdef TRACE_TS_ONLY_EN
    assign w_regw_ok = (i_wb_reg >= 5'd8) && (i_wb_reg <= 5'd23);
`else
    assign w_regw_ok = (i_wb_reg != 5'd0);
`endif

    assign w_regw_ev  = i_trace_en & i_wb_regwrite & w_regw_ok;
    assign w_mem_ev   = i_trace_en & (i_mem_read | i_mem_write);
    assign w_proto    = i_trace_en & i_mem_read & i_mem_write;
    // A simultaneous read+write is reported as a single store.
    assign w_mem_type = i_mem_write ? 2'b11 : 2'b10;

    assign w_regw_entry = {2'b01, i_wb_reg, 9'b0, i_wb_pc[15:0], i_wb_data};
    assign w_mem_entry  = {w_mem_type, 5'b0, 9'b0, i_mem_addr[15:0], i_mem_data};

    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign w_next    = r_mem[r_rd_ptr[AW-1:0] + AW'(1)];
    assign w_mem_idx = r_wr_ptr[AW-1:0] + AW'(w_push_regw);
    assign w_pop     = (r_state == StVal) && i_out_ready;

    assign w_unused_bits = ^{i_wb_pc[31:16], i_mem_addr[31:16]};

    // Admission: the register write is the older instruction and gets space first.
    always_comb begin
        w_push_regw = 1'b0;
        w_push_mem  = 1'b0;
        if (w_regw_ev && (w_free != '0)) begin
            w_push_regw = 1'b1;
        end
        if (w_mem_ev) begin
            w_push_mem = w_push_regw ? (w_free >= (AW+1)'(2)) : (w_free != '0);
        end
        w_n_drop = {1'b0, w_regw_ev & ~w_push_regw} + {1'b0, w_mem_ev & ~w_push_mem};
    end

    // Saturating next value of the drop counter.
    always_comb begin
        w_drop_sum   = {1'b0, r_drop_cnt} + (DROP_W+1)'(w_n_drop);
        w_drop_cnt_d = w_drop_sum[DROP_W] ? '1 : w_drop_sum[DROP_W-1:0];
    end

    // Event storage; contents need no reset since pointers qualify them.
    always_ff @(posedge clk) begin
        if (w_push_regw) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_regw_entry;
        end
        if (w_push_mem) begin
            r_mem[w_mem_idx] <= w_mem_entry;
        end
    end

    // Queue pointers and sticky status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_proto_err <= 1'b0;
            r_drop_cnt  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + (AW+1)'(w_push_regw) + (AW+1)'(w_push_mem);
            r_rd_ptr <= r_rd_ptr + (AW+1)'(w_pop);
            if (w_proto) begin
                r_proto_err <= 1'b1;
            end
            if (w_n_drop != 2'd0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_cnt_d;
            end
        end
    end

    // Packet FSM with registered beat outputs; chains packets without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_count != '0) begin
                        r_state     <= StHdr;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_head[63:32];
                        r_out_last  <= 1'b0;
                    end
                end
                StHdr: begin
                    if (i_out_ready) begin
                        r_state    <= StVal;
                        r_out_data <= w_head[31:0];
                        r_out_last <= 1'b1;
                    end
                end
                StVal: begin
                    if (i_out_ready) begin
                        if (w_count > (AW+1)'(1)) begin
                            r_state    <= StHdr;
                            r_out_data <= w_next[63:32];
                            r_out_last <= 1'b0;
                        end else begin
                            r_state     <= StIdle;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_last  <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_out_last  <= 1'b0;
                end
            endcase
        end
    end

    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_overflow  = r_overflow;
    assign o_proto_err = r_proto_err;
    assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_commit_trace_tx.sv
// Bench for commit_trace_tx: directed scenarios plus random traffic, with an
// event-level reference model feeding a scoreboard of expected beats.
module tb_commit_trace_tx;
    localparam int DEPTH  = 16;
    localparam int DROP_W = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_trace_en, i_wb_regwrite, i_mem_read, i_mem_write, i_out_ready;
    logic [4:0]        i_wb_reg;
    logic [31:0]       i_wb_data, i_wb_pc, i_mem_addr, i_mem_data;
    logic              o_out_valid, o_out_last, o_overflow, o_proto_err;
    logic [31:0]       o_out_data;
    logic [DROP_W-1:0] o_drop_cnt;

    always #5 clk = ~clk;

    commit_trace_tx #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_trace_en   (i_trace_en),
        .i_wb_regwrite(i_wb_regwrite),
        .i_wb_reg     (i_wb_reg),
        .i_wb_data    (i_wb_data),
        .i_wb_pc      (i_wb_pc),
        .i_mem_read   (i_mem_read),
        .i_mem_write  (i_mem_write),
        .i_mem_addr   (i_mem_addr),
        .i_mem_data   (i_mem_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_out_last   (o_out_last),
        .o_overflow   (o_overflow),
        .o_proto_err  (o_proto_err),
        .o_drop_cnt   (o_drop_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t             exp_q[$];
    int                total = 0;
    int                bad = 0;
    int                n_beats = 0;
    int                m_count = 0;
    logic              m_ovf = 1'b0;
    logic              m_proto = 1'b0;
    logic [DROP_W-1:0] m_drop = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit reg_recorded(input logic [4:0] r);
`ifdef TRACE_TS_ONLY_EN
        return (r >= 5'd8) && (r <= 5'd23);
`else
        return r != 5'd0;
`endif
    endfunction

    // One event offered to the queue: kept as two expected beats, or dropped.
    task automatic add_event(input logic [1:0] typ, input logic [4:0] rg, input logic [15:0] a,
                             input logic [31:0] val, inout int free, inout int accepted);
        beat_t b;
        if (free > 0) begin
            b.data = ({30'd0, typ} << 30) | ({27'd0, rg} << 25) | {16'd0, a};
            b.last = 1'b0;
            exp_q.push_back(b);
            b.data = val;
            b.last = 1'b1;
            exp_q.push_back(b);
            free--;
            accepted++;
        end else begin
            m_ovf = 1'b1;
            if (m_drop != {DROP_W{1'b1}}) m_drop = m_drop + 1'b1;
        end
    endtask

    // Reference model: at each falling edge predict what the coming rising edge does.
    always @(negedge clk) begin
        int free;
        int accepted;
        int pops;
        if (!rst_n) begin
            exp_q.delete();
            m_count = 0;
            m_ovf   = 1'b0;
            m_proto = 1'b0;
            m_drop  = '0;
        end
        check("overflow", o_overflow, m_ovf);
        check("proto_err", o_proto_err, m_proto);
        check("drop_cnt", o_drop_cnt, m_drop);
        if (rst_n) begin
            pops     = (o_out_valid && i_out_ready && o_out_last) ? 1 : 0;
            free     = DEPTH - m_count;
            accepted = 0;
            if (i_trace_en) begin
                if (i_mem_read && i_mem_write) m_proto = 1'b1;
                if (i_wb_regwrite && reg_recorded(i_wb_reg))
                    add_event(2'b01, i_wb_reg, i_wb_pc[15:0], i_wb_data, free, accepted);
                if (i_mem_read || i_mem_write)
                    add_event(i_mem_write ? 2'b11 : 2'b10, 5'd0, i_mem_addr[15:0], i_mem_data,
                              free, accepted);
            end
            m_count = m_count + accepted - pops;
        end
    end

    // Monitor: compares each accepted beat and checks hold-stability under stall.
    logic        stall_v = 1'b0;
    logic [31:0] stall_d;
    logic        stall_l;
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v) begin
                check("hold_valid", o_out_valid, 1);
                check("hold_data", o_out_data, stall_d);
                check("hold_last", o_out_last, stall_l);
            end
            if (o_out_valid && i_out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat actual=%0h required=none at %0t",
                             o_out_data, $time);
                end else begin
                    b = exp_q.pop_front();
                    check("beat_data", o_out_data, b.data);
                    check("beat_last", o_out_last, b.last);
                end
                n_beats++;
                stall_v = 1'b0;
            end else if (o_out_valid) begin
                stall_v = 1'b1;
                stall_d = o_out_data;
                stall_l = o_out_last;
            end else begin
                stall_v = 1'b0;
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        i_trace_en    = 1'b1;
        i_wb_regwrite = 1'b0;
        i_wb_reg      = '0;
        i_wb_data     = '0;
        i_wb_pc       = '0;
        i_mem_read    = 1'b0;
        i_mem_write   = 1'b0;
        i_mem_addr    = '0;
        i_mem_data    = '0;
    endtask

    task automatic do_reset();
        clear_in();
        i_out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_valid", o_out_valid, 0);
        check("rst_data", o_out_data, 0);
        check("rst_last", o_out_last, 0);
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic drive_regw(input logic [4:0] rg, input logic [31:0] d, input logic [31:0] pc);
        i_wb_regwrite = 1'b1;
        i_wb_reg      = rg;
        i_wb_data     = d;
        i_wb_pc       = pc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   nb0;
        int   thr;
        bit   found;
        logic [31:0] held;

        // 1: single register write, latency and packet format
        do_reset();
        i_out_ready = 1'b1;
        drive_regw(5'd9, 32'd5, 32'h14);
        cycle();
        clear_in();
        check("t1_lat_idle", o_out_valid, 0);
        cycle();
        check("t1_hdr_valid", o_out_valid, 1);
        check("t1_hdr", o_out_data, 32'h5200_0014);
        check("t1_hdr_last", o_out_last, 0);
        cycle();
        check("t1_val", o_out_data, 32'd5);
        check("t1_val_last", o_out_last, 1);
        cycle();
        check("t1_done", o_out_valid, 0);

        // 2: same-cycle REGW + MEMW, back-to-back beats
        do_reset();
        i_out_ready = 1'b1;
        drive_regw(5'd8, 32'd7, $urandom);
        i_mem_write = 1'b1;
        i_mem_addr  = 32'h20;
        i_mem_data  = 32'd7;
        cycle();
        clear_in();
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("t2_no_bubble", o_out_valid, 1);
            if (i == 2) check("t2_mem_hdr", o_out_data, 32'hC000_0020);
        end
        cycle();
        check("t2_done", o_out_valid, 0);

        // 3: overflow with a stalled sink, then full drain
        do_reset();
        for (int i = 0; i < 20; i++) begin
            i_mem_read = 1'b1;
            i_mem_addr = 32'(i * 4);
            i_mem_data = $urandom;
            cycle();
        end
        clear_in();
        cycle();
        check("t3_drop_cnt", o_drop_cnt, 4);
        check("t3_overflow", o_overflow, 1);
        nb0 = n_beats;
        i_out_ready = 1'b1;
        repeat (40) cycle();
        check("t3_beats", n_beats - nb0, 32);
        check("t3_empty", o_out_valid, 0);

        // 4: stall on beat1, then asynchronous reset mid-packet
        do_reset();
        i_out_ready = 1'b1;
        drive_regw(5'd12, $urandom, $urandom);
        cycle();
        clear_in();
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (o_out_valid && o_out_last) found = 1'b1;
        end
        check("t4_reach_beat1", found, 1);
        i_out_ready = 1'b0;
        held = o_out_data;
        repeat (5) cycle();
        check("t4_stall_data", o_out_data, held);
        check("t4_stall_last", o_out_last, 1);
        rst_n = 1'b0;
        #1;
        check("t4_rst_valid", o_out_valid, 0);
        check("t4_rst_last", o_out_last, 0);
        cycle();
        rst_n = 1'b1;
        i_out_ready = 1'b1;
        repeat (5) cycle();
        check("t4_queue_empty", o_out_valid, 0);

        // 5: read+write together, and a write to $zero
        do_reset();
        i_out_ready = 1'b1;
        nb0 = n_beats;
        i_mem_read  = 1'b1;
        i_mem_write = 1'b1;
        i_mem_addr  = 32'h40;
        i_mem_data  = $urandom;
        cycle();
        clear_in();
        drive_regw(5'd0, $urandom, $urandom);
        cycle();
        clear_in();
        repeat (6) cycle();
        check("t5_proto_err", o_proto_err, 1);
        check("t5_drop_cnt", o_drop_cnt, 0);
        check("t5_beats", n_beats - nb0, 2);

        // 6: register filter
        do_reset();
        i_out_ready = 1'b1;
        nb0 = n_beats;
        drive_regw(5'd2, $urandom, $urandom);
        cycle();
        drive_regw(5'd23, $urandom, 32'h1234_ABCD);
        cycle();
        clear_in();
        repeat (8) cycle();
`ifdef TRACE_TS_ONLY_EN
        check("t6_beats", n_beats - nb0, 2);
`else
        check("t6_beats", n_beats - nb0, 4);
`endif

        // Random traffic with varying backpressure and trace enable
        do_reset();
        for (int blk = 0; blk < 12; blk++) begin
            thr = 20 + int'($urandom_range(0, 80));
            for (int i = 0; i < 250; i++) begin
                i_trace_en    = ($urandom_range(0, 7) != 0);
                i_wb_regwrite = $urandom_range(0, 1) == 1;
                i_wb_reg      = 5'($urandom);
                i_wb_data     = $urandom;
                i_wb_pc       = $urandom;
                i_mem_read    = $urandom_range(0, 9) < 3;
                i_mem_write   = $urandom_range(0, 9) < 3;
                i_mem_addr    = $urandom;
                i_mem_data    = $urandom;
                i_out_ready   = $urandom_range(0, 99) < thr;
                cycle();
            end
        end
        clear_in();
        i_out_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || o_out_valid); i++) cycle();
        check("rand_drain_q", exp_q.size(), 0);
        check("rand_drain_valid", o_out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
